mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage placed directly downstream of the execute stage and upstream of write-back. It latches the 103-bit execute bundle, waits for the data-SRAM response of any request issued by execute, and buffers that response so a write-back stall never loses it. For loads it aligns and sign/zero-extends the returned word. It forwards the final result to write-back and exposes a bypass/stall bundle to decode.

## Interface
Parameters: none (widths fixed by pipeline bus layout).
- clk  in  1  pipeline clock
- resetn  in  1  synchronous active-low reset
- ex_mem_valid  in  1  execute offers an instruction
- mem_allowin  out  1  stage can accept this cycle
- ex_mem_bus  in  103  {gr_we, res_from_mem, dest[4:0], pc[31:0], inst[31:0], result[31:0]}; result is ALU/divide result, or byte address for memory ops
- ex_mem_req  in  1  sampled with the bus: a data-SRAM request was issued and accepted for this instruction; a response is owed
- data_sram_data_ok  in  1  one-cycle pulse: response for oldest outstanding request
- data_sram_rdata  in  32  response data, valid with data_ok
- mem_wb_valid  out  1  stage offers an instruction to write-back
- wb_allowin  in  1  write-back accepts
- mem_wb_bus  out  102  {gr_we, dest[4:0], pc[31:0], inst[31:0], final_result[31:0]}
- mem_id_bus  out  39  {mem_bypass, mem_ld_pending, dest[4:0], final_result[31:0]}

## Operation
- Capture register: loads ex_mem_bus and ex_mem_req when ex_mem_valid & mem_allowin; mem_valid <= ex_mem_valid whenever mem_allowin.
- Response FSM, three states:
  - EMPTY: no instruction, or instruction with ex_mem_req=0.
  - WAIT: instruction captured with ex_mem_req=1, no data yet. data_ok -> HOLD (rdata into buffer) unless leaving the same cycle.
  - HOLD: buffered rdata valid; leaves on handshake with write-back.
- ready_go = ~req_pending | data_ok | buf_valid.
- mem_wb_valid = mem_valid & ready_go; mem_allowin = ~mem_valid | (ready_go & wb_allowin).
- Same-cycle data_ok and write-back handshake: instruction departs using live rdata; buffer not written; FSM goes to state implied by the incoming instruction (WAIT if new ex_mem_req=1, else EMPTY).
- data_ok in EMPTY (no pending request): ignored, no state change.
- Stores (ex_mem_req=1, res_from_mem=0): wait for data_ok as acknowledge; final_result = captured result.
- Load extension, op from inst[31:22], byte offset a = result[1:0], word w = selected rdata (live or buffer):
  - 0x0A0 ld.b: sign-extend w[8a+7:8a]
  - 0x0A8 ld.bu: zero-extend w[8a+7:8a]
  - 0x0A1 ld.h: sign-extend w[16a1+15:16a1], a1=result[1]
  - 0x0A9 ld.hu: zero-extend same halfword
  - 0x0A2 ld.w and any other res_from_mem op: w unmodified; misalignment not checked here
- final_result = res_from_mem ? extended load : result.
- mem_bypass = mem_valid & gr_we; mem_ld_pending = mem_valid & res_from_mem & ~ready_go (decode must stall consumers of dest while 1).

## Timing
- Reset (resetn=0 at clk edge): mem_valid=0, FSM=EMPTY, buf_valid=0; hence mem_wb_valid=0, mem_allowin=1, mem_bypass=0, mem_ld_pending=0. Bus/buffer data registers not reset.
- Earliest data_ok is the cycle after capture (one-cycle minimum latency through stage); no upper bound.
- Non-memory instruction: mem_wb_valid=1 the cycle after capture.
- All outputs combinational from stage registers plus data_ok/rdata/wb_allowin; no path from ex_mem_valid to mem_allowin.
- Response arriving after a reset that discarded its request: ignored per EMPTY rule; ordering after reset is the memory system's responsibility.
- Back-to-back: with wb_allowin=1 and data_ok each cycle, one instruction per cycle.

## Test plan
- Reset then add: resetn=0 2 cycles, feed gr_we=1, dest=5, result=0x1234, ex_mem_req=0 -> next cycle mem_wb_valid=1, final_result=0x00001234, mem_bypass=1.
- ld.b at result=0x1003, data_ok same cycle after capture with rdata=0x80AA55CC -> final_result=0xFFFFFF80; ld.bu same -> 0x00000080.
- ld.hu at result=0x2002, data_ok 3 cycles late, rdata=0xBEEF0001 -> mem_ld_pending=1 for 3 cycles, mem_wb_valid=0, then final_result=0x0000BEEF.
- ld.w, wb_allowin=0 when data_ok (rdata=0xDEADBEEF) arrives, held 4 cycles, rdata changes to 0 -> mem_wb_valid stays 1, final_result=0xDEADBEEF on release, mem_allowin=0 until handshake.
- Store with ex_mem_req=1 followed by non-memory op, data_ok on same cycle wb_allowin=1 -> store leaves, next op captured same edge, no spurious HOLD.
- Stray data_ok with stage EMPTY -> no mem_wb_valid, next load still waits for its own data_ok.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: captures the execute bundle, collects the data-SRAM
// response (buffering it across write-back stalls) and aligns load data.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ex_mem_valid,
    output logic         mem_allowin,
    input  logic [102:0] ex_mem_bus,
    input  logic         ex_mem_req,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic         mem_wb_valid,
    input  logic         wb_allowin,
    output logic [101:0] mem_wb_bus,
    output logic [38:0]  mem_id_bus
);

    typedef struct packed {
        logic        gr_we;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
    } ex_mem_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] final_result;
    } mem_wb_t;

    typedef struct packed {
        logic        mem_bypass;
        logic        mem_ld_pending;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } mem_id_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } rsp_state_t;

    localparam logic [9:0] OP_LD_B  = 10'h0A0;
    localparam logic [9:0] OP_LD_H  = 10'h0A1;
    localparam logic [9:0] OP_LD_BU = 10'h0A8;
    localparam logic [9:0] OP_LD_HU = 10'h0A9;

    ex_mem_t    mem_r;
    logic       mem_valid;
    rsp_state_t state;
    rsp_state_t state_nxt;
    logic [31:0] rdata_buf;

    logic        req_pending;
    logic        buf_valid;
    logic        ready_go;
    logic        accept;
    logic        buf_we;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] final_result;
    logic [9:0]  op;

    mem_wb_t wb_out;
    mem_id_t id_out;

    assign req_pending  = (state == ST_WAIT);
    assign buf_valid    = (state == ST_HOLD);
    assign ready_go     = ~req_pending | data_sram_data_ok | buf_valid;
    assign mem_wb_valid = mem_valid & ready_go;
    assign mem_allowin  = ~mem_valid | (ready_go & wb_allowin);
    assign accept       = ex_mem_valid & mem_allowin;

    // Buffer only when the response arrives but the instruction cannot leave.
    assign buf_we = req_pending & data_sram_data_ok & ~mem_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            state     <= ST_EMPTY;
        end else begin
            if (mem_allowin) begin
                mem_valid <= ex_mem_valid;
            end
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_r <= ex_mem_t'(ex_mem_bus);
        end
        if (buf_we) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mem_allowin) begin
            state_nxt = (ex_mem_valid & ex_mem_req) ? ST_WAIT : ST_EMPTY;
        end else if (buf_we) begin
            state_nxt = ST_HOLD;
        end
    end

    assign ld_word = buf_valid ? rdata_buf : data_sram_rdata;
    assign op      = mem_r.inst[31:22];

    always_comb begin
        ld_byte = ld_word[7:0];
        unique case (mem_r.result[1:0])
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
    end

    assign ld_half = mem_r.result[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_value = ld_word;
        unique case (1'b1)
            (op == OP_LD_B):  ld_value = {{24{ld_byte[7]}}, ld_byte};
            (op == OP_LD_BU): ld_value = {24'd0, ld_byte};
            (op == OP_LD_H):  ld_value = {{16{ld_half[15]}}, ld_half};
            (op == OP_LD_HU): ld_value = {16'd0, ld_half};
            default:          ld_value = ld_word;
        endcase
    end

    assign final_result = mem_r.res_from_mem ? ld_value : mem_r.result;

    always_comb begin
        wb_out.gr_we        = mem_r.gr_we;
        wb_out.dest         = mem_r.dest;
        wb_out.pc           = mem_r.pc;
        wb_out.inst         = mem_r.inst;
        wb_out.final_result = final_result;
    end

    always_comb begin
        id_out.mem_bypass     = mem_valid & mem_r.gr_we;
        id_out.mem_ld_pending = mem_valid & mem_r.res_from_mem & ~ready_go;
        id_out.dest           = mem_r.dest;
        id_out.final_result   = final_result;
    end

    assign mem_wb_bus = wb_out;
    assign mem_id_bus = id_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, load extension,
// late and stalled responses, store acknowledge and stray responses.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         ex_mem_valid;
    logic         mem_allowin;
    logic [102:0] ex_mem_bus;
    logic         ex_mem_req;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [101:0] mem_wb_bus;
    logic [38:0]  mem_id_bus;

    int n_cmp;
    int n_bad;

    localparam logic [31:0] I_ALU  = 32'h0010_0000;
    localparam logic [31:0] I_LDB  = {10'h0A0, 22'h0};
    localparam logic [31:0] I_LDH  = {10'h0A1, 22'h0};
    localparam logic [31:0] I_LDW  = {10'h0A2, 22'h0};
    localparam logic [31:0] I_LDBU = {10'h0A8, 22'h0};
    localparam logic [31:0] I_LDHU = {10'h0A9, 22'h0};
    localparam logic [31:0] I_ST   = {10'h0A6, 22'h0};

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_mem_valid      (ex_mem_valid),
        .mem_allowin       (mem_allowin),
        .ex_mem_bus        (ex_mem_bus),
        .ex_mem_req        (ex_mem_req),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_wb_valid      (mem_wb_valid),
        .wb_allowin        (wb_allowin),
        .mem_wb_bus        (mem_wb_bus),
        .mem_id_bus        (mem_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge; stage must be accepting.
    task automatic offer(input logic we, input logic rfm, input logic [4:0] d,
                         input logic [31:0] inst, input logic [31:0] res,
                         input logic req);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = {we, rfm, d, 32'h1C00_0000, inst, res};
        ex_mem_req   = req;
        #1;
        chk("offer_allowin", 32'(mem_allowin), 32'd1);
        tick();
        ex_mem_valid = 1'b0;
        ex_mem_req   = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        ex_mem_valid = 1'b0;
        ex_mem_bus = '0;
        ex_mem_req = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        wb_allowin = 1'b1;
        tick();
        tick();
        chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_allowin", 32'(mem_allowin), 32'd1);
        chk("rst_bypass", 32'(mem_id_bus[38]), 32'd0);
        chk("rst_ld_pend", 32'(mem_id_bus[37]), 32'd0);
        resetn = 1'b1;
        #1;

        // ALU result pass-through
        offer(1'b1, 1'b0, 5'd5, I_ALU, 32'h0000_1234, 1'b0);
        chk("add_wb_valid", 32'(mem_wb_valid), 32'd1);
        chk("add_result", mem_wb_bus[31:0], 32'h0000_1234);
        chk("add_wb_dest", 32'(mem_wb_bus[100:96]), 32'd5);
        chk("add_bypass", 32'(mem_id_bus[38]), 32'd1);
        chk("add_id_dest", 32'(mem_id_bus[36:32]), 32'd5);
        chk("add_id_res", mem_id_bus[31:0], 32'h0000_1234);
        tick();
        chk("add_gone", 32'(mem_wb_valid), 32'd0);

        // ld.b / ld.bu, response in first cycle in stage
        offer(1'b1, 1'b1, 5'd6, I_LDB, 32'h0000_1003, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80AA_55CC;
        #1;
        chk("ldb_valid", 32'(mem_wb_valid), 32'd1);
        chk("ldb_res", mem_wb_bus[31:0], 32'hFFFF_FF80);
        chk("ldb_pend", 32'(mem_id_bus[37]), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        offer(1'b1, 1'b1, 5'd6, I_LDBU, 32'h0000_1003, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        chk("ldbu_res", mem_wb_bus[31:0], 32'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;
        offer(1'b1, 1'b1, 5'd6, I_LDB, 32'h0000_1001, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        chk("ldb_off1_res", mem_wb_bus[31:0], 32'h0000_0055);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.hu, response three cycles late
        offer(1'b1, 1'b1, 5'd7, I_LDHU, 32'h0000_2002, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("ldhu_pend", 32'(mem_id_bus[37]), 32'd1);
            chk("ldhu_novalid", 32'(mem_wb_valid), 32'd0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_0001;
        #1;
        chk("ldhu_valid", 32'(mem_wb_valid), 32'd1);
        chk("ldhu_res", mem_wb_bus[31:0], 32'h0000_BEEF);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.h low half, negative
        offer(1'b1, 1'b1, 5'd8, I_LDH, 32'h0000_6000, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1234_8001;
        #1;
        chk("ldh_res", mem_wb_bus[31:0], 32'hFFFF_8001);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.w response arrives during write-back stall
        offer(1'b1, 1'b1, 5'd9, I_LDW, 32'h0000_3000, 1'b1);
        wb_allowin = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ldw_valid", 32'(mem_wb_valid), 32'd1);
        chk("ldw_allowin", 32'(mem_allowin), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(mem_wb_valid), 32'd1);
            chk("hold_res", mem_wb_bus[31:0], 32'hDEAD_BEEF);
            chk("hold_allowin", 32'(mem_allowin), 32'd0);
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        chk("rel_res", mem_wb_bus[31:0], 32'hDEAD_BEEF);
        chk("rel_allowin", 32'(mem_allowin), 32'd1);
        tick();
        chk("rel_gone", 32'(mem_wb_valid), 32'd0);

        // store ack coincides with handshake and next capture
        offer(1'b0, 1'b0, 5'd0, I_ST, 32'h0000_4444, 1'b1);
        chk("st_wait_valid", 32'(mem_wb_valid), 32'd0);
        chk("st_wait_allowin", 32'(mem_allowin), 32'd0);
        chk("st_no_bypass", 32'(mem_id_bus[38]), 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_5555;
        ex_mem_valid = 1'b1;
        ex_mem_bus = {1'b1, 1'b0, 5'd7, 32'h1C00_0040, I_ALU, 32'h0000_0077};
        ex_mem_req = 1'b0;
        #1;
        chk("st_valid", 32'(mem_wb_valid), 32'd1);
        chk("st_res", mem_wb_bus[31:0], 32'h0000_4444);
        chk("st_allowin", 32'(mem_allowin), 32'd1);
        tick();
        ex_mem_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("nxt_valid", 32'(mem_wb_valid), 32'd1);
        chk("nxt_res", mem_wb_bus[31:0], 32'h0000_0077);
        chk("nxt_dest", 32'(mem_wb_bus[100:96]), 32'd7);
        tick();
        chk("nxt_gone", 32'(mem_wb_valid), 32'd0);

        // stray response while empty is ignored
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_1111;
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("stray_valid", 32'(mem_wb_valid), 32'd0);
        offer(1'b1, 1'b1, 5'd10, I_LDW, 32'h0000_5000, 1'b1);
        chk("stray_ld_wait", 32'(mem_wb_valid), 32'd0);
        chk("stray_ld_pend", 32'(mem_id_bus[37]), 32'd1);
        tick();
        chk("stray_ld_wait2", 32'(mem_wb_valid), 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h2222_2222;
        #1;
        chk("stray_ld_res", mem_wb_bus[31:0], 32'h2222_2222);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("end_empty", 32'(mem_wb_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
